display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Upstream stage of the 4-digit seven-segment multiplexer.
- Generates the 2-bit `scan` digit select at a divided refresh rate.
- Double-buffers the game-side display data (`hexs`, `points`, `LEs`) so that updates take effect only on frame boundaries. This prevents tearing mid-scan.
- Optionally blanks leading zeros before the data reaches the digit mux.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz frame); legal range 2..2^20.
- BLANK_LZ, 1, 1 = force leading-zero digits blank; 0 = pass `LEs` through unchanged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  scan enable; 0 freezes divider and scan
- wr  in  1  single-cycle load strobe for the shadow buffer
- hexs_in  in  16  four hex digits, [3:0] = digit 0 (rightmost)
- points_in  in  4  decimal points, bit i = digit i
- les_in  in  4  blank requests, bit i = 1 blanks digit i
- scan  out  2  current digit index, to the digit mux
- hexs  out  16  active (committed) hex digits
- points  out  4  active decimal points
- LEs  out  4  active blank mask after leading-zero processing (1 = blank)
- pending  out  1  shadow holds data not yet committed
- frame_done  out  1  one-cycle pulse when scan wraps 3 -> 0

Behaviour:
- Reset (synchronous, highest priority, applies mid-operation):
  - divider count = 0, scan = 0
  - hexs = 16'h0000, points = 4'h0, LEs = 4'hF (all blank)
  - shadow cleared, pending = 0, frame_done = 0
- Divider: count runs 0..CLK_DIV-1 while en = 1.
  - tick = en && count == CLK_DIV-1.
  - On tick, count returns to 0. When en = 0, count holds its value.
- Scan: scan increments modulo 4 on the clock edge where tick is asserted.
  - scan is registered; no glitches.
  - Each digit is held for exactly CLK_DIV cycles.
- frame_done: asserted for the single cycle following the edge on which scan goes 3 -> 0.
- Shadow write: on wr = 1, {hexs_in, points_in, les_in} are captured into the shadow and pending is set to 1 on the next edge.
  - Back-to-back wr: the last write wins; no queueing.
- Commit:
  - Trigger: tick while scan == 3 (frame boundary), or any cycle with en = 0.
  - If pending = 1, copy shadow to active on that edge and clear pending.
  - Commit is visible in the same cycle scan reads 0.
- Simultaneous wr and commit:
  - The commit copies the old shadow.
  - The new data is captured into the shadow and pending stays 1.
  - That data commits at the next boundary.
- Leading-zero blanking: computed from shadow data at commit and registered with it (no combinational path from inputs to outputs).
  - When BLANK_LZ = 1: digit 3 is forced blank if hex[15:12] == 0.
  - Digit 2 is forced blank if digits 3 and 2 are both 0.
  - Digit 1 is forced blank if digits 3, 2 and 1 are all 0.
  - Digit 0 is never forced blank.
  - Final LEs = les_in OR forced mask.
  - Blanking ignores points; a digit with its point set is still blanked if it is a leading zero.
- Latency: data written at any time is displayed at most 4*CLK_DIV + 1 cycles later while en = 1, and 1 cycle later while en = 0.
- Outputs change only on clk edges; all state is held when en = 0, except the commit path.

Test Plan:
- Reset check: rst for 2 cycles, CLK_DIV = 4, en = 1 → scan 0 for 4 cycles, then 1, 2, 3, 0 every 4 cycles; frame_done pulses once per 16 cycles; LEs = 4'hF until the first commit.
- Frame-boundary commit: wr with hexs_in = 16'h1234 while scan = 1 → pending = 1 and hexs unchanged until the edge where scan goes 3 -> 0; then hexs = 16'h1234, pending = 0.
- Collision: wr 16'hAAAA at scan = 2, then wr 16'h5555 exactly on the commit edge → hexs = 16'hAAAA with pending = 1 after the boundary; hexs = 16'h5555 after the next boundary.
- Leading zeros: BLANK_LZ = 1, write 16'h0070 with les_in = 0 → LEs = 4'b1100. Write 16'h0000 → LEs = 4'b1110. With BLANK_LZ = 0, 16'h0070 → LEs = 4'b0000.
- Enable freeze: drop en at scan = 2, count = 1 for 10 cycles and wr 16'hBEEF → scan and count frozen; hexs = 16'hBEEF one cycle after wr. Re-raise en → scan advances after 3 more cycles.
- Reset mid-frame: rst asserted at scan = 3 with pending = 1 → next cycle scan = 0, pending = 0, hexs = 0, LEs = 4'hF, and no frame_done pulse.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the game logic and the scan controller: shadow-write inputs
// going in, committed display data and scan index coming out.
interface display_scan_ctrl_if;
   logic        en;
   logic        wr;
   logic [15:0] hexs_in;
   logic [3:0]  points_in;
   logic [3:0]  les_in;
   logic [1:0]  scan;
   logic [15:0] hexs;
   logic [3:0]  points;
   logic [3:0]  LEs;
   logic        pending;
   logic        frame_done;

   modport master (
      output en, wr, hexs_in, points_in, les_in,
      input  scan, hexs, points, LEs, pending, frame_done
   );

   modport slave (
      input  en, wr, hexs_in, points_in, les_in,
      output scan, hexs, points, LEs, pending, frame_done
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Refresh-rate digit scanner with a double-buffered display image that only
// swaps on frame boundaries (or immediately while scanning is paused).
module display_scan_ctrl #(
   parameter int CLK_DIV  = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   display_scan_ctrl_if.slave bus
);

   localparam int             CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_count;
   logic [1:0]    r_scan;
   logic          r_frameDone;
   logic [15:0]   r_shHexs;
   logic [3:0]    r_shPoints;
   logic [3:0]    r_shLes;
   logic          r_pending;
   logic [15:0]   r_hexs;
   logic [3:0]    r_points;
   logic [3:0]    r_les;

   logic          w_tick;
   logic          w_boundary;
   logic          w_commit;
   logic [3:0]    w_lzMask;

   assign w_tick     = bus.en && (r_count == LAST);
   assign w_boundary = w_tick && (r_scan == 2'd3);
   assign w_commit   = w_boundary || !bus.en;

   // Leading-zero mask is derived from the shadow so it registers with the commit.
   always_comb begin
      w_lzMask = 4'b0000;
      if (BLANK_LZ) begin
         w_lzMask[3] = (r_shHexs[15:12] == 4'h0);
         w_lzMask[2] = w_lzMask[3] && (r_shHexs[11:8] == 4'h0);
         w_lzMask[1] = w_lzMask[2] && (r_shHexs[7:4] == 4'h0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_scan      <= 2'd0;
         r_frameDone <= 1'b0;
      end else begin
         if (w_tick) begin
            r_count <= '0;
            r_scan  <= r_scan + 2'd1;
         end else if (bus.en) begin
            r_count <= r_count + 1'b1;
         end
         r_frameDone <= w_boundary;
      end
   end

   // A commit on the same edge as a write takes the old shadow; the new data waits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shHexs   <= 16'h0000;
         r_shPoints <= 4'h0;
         r_shLes    <= 4'h0;
         r_pending  <= 1'b0;
         r_hexs     <= 16'h0000;
         r_points   <= 4'h0;
         r_les      <= 4'hF;
      end else begin
         if (w_commit && r_pending) begin
            r_hexs   <= r_shHexs;
            r_points <= r_shPoints;
            r_les    <= r_shLes | w_lzMask;
         end
         if (bus.wr) begin
            r_shHexs   <= bus.hexs_in;
            r_shPoints <= bus.points_in;
            r_shLes    <= bus.les_in;
            r_pending  <= 1'b1;
         end else if (w_commit) begin
            r_pending  <= 1'b0;
         end
      end
   end

   assign bus.scan       = r_scan;
   assign bus.hexs       = r_hexs;
   assign bus.points     = r_points;
   assign bus.LEs        = r_les;
   assign bus.pending    = r_pending;
   assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl; two instances differ only
// in leading-zero blanking and are compared against an arithmetic frame model.
module tb_display_scan_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr;
   logic [15:0] hexsIn;
   logic [3:0]  pointsIn;
   logic [3:0]  lesIn;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   display_scan_ctrl_if ifA ();
   display_scan_ctrl_if ifB ();

   assign ifA.en = en;  assign ifA.wr = wr;  assign ifA.hexs_in = hexsIn;
   assign ifA.points_in = pointsIn;  assign ifA.les_in = lesIn;
   assign ifB.en = en;  assign ifB.wr = wr;  assign ifB.hexs_in = hexsIn;
   assign ifB.points_in = pointsIn;  assign ifB.les_in = lesIn;

   display_scan_ctrl #(.CLK_DIV(D), .BLANK_LZ(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
   display_scan_ctrl #(.CLK_DIV(D), .BLANK_LZ(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

   // Model: scan position follows from the number of enabled cycles since reset.
   int          eCycles;
   logic [15:0] mShHex, mHex;
   logic [3:0]  mShPt, mShLes, mPt, mLesRaw;
   bit          mPending, mFd;

   function automatic int curScan();
      return (eCycles / D) % 4;
   endfunction

   function automatic logic [3:0] lzMask(input logic [15:0] h);
      logic [3:0] m;
      m = 4'b0000;
      for (int i = 3; i >= 1; i--) begin
         if (h[i*4 +: 4] != 4'h0) break;
         m[i] = 1'b1;
      end
      return m;
   endfunction

   task automatic modelEdge();
      bit boundary;
      if (rst) begin
         eCycles = 0; mShHex = 0; mShPt = 0; mShLes = 0; mPending = 0;
         mHex = 0; mPt = 0; mLesRaw = 4'hF; mFd = 0;
      end else begin
         boundary = en && ((eCycles + 1) % (4 * D) == 0);
         if ((boundary || !en) && mPending) begin
            mHex = mShHex; mPt = mShPt; mLesRaw = mShLes; mPending = 0;
         end
         if (wr) begin
            mShHex = hexsIn; mShPt = pointsIn; mShLes = lesIn; mPending = 1;
         end
         mFd = boundary;
         if (en) eCycles++;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] expLesA();
      // Reset state is all-blank and is not subject to leading-zero forcing.
      return (mLesRaw == 4'hF) ? 4'hF : (mLesRaw | lzMask(mHex));
   endfunction

   task automatic applyStimulus();
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput("scan",       32'(ifA.scan),       32'(curScan()));
      checkOutput("hexs",       32'(ifA.hexs),       32'(mHex));
      checkOutput("points",     32'(ifA.points),     32'(mPt));
      checkOutput("LEsA",       32'(ifA.LEs),        32'(expLesA()));
      checkOutput("LEsB",       32'(ifB.LEs),        32'(mLesRaw));
      checkOutput("pending",    32'(ifA.pending),    32'(mPending));
      checkOutput("frame_done", 32'(ifA.frame_done), 32'(mFd));
      checkOutput("scanB",      32'(ifB.scan),       32'(curScan()));
   endtask

   task automatic writeData(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
      hexsIn = h; pointsIn = p; lesIn = l; wr = 1'b1;
      applyStimulus();
      wr = 1'b0;
   endtask

   task automatic waitScan(input int target);
      int k = 0;
      while (curScan() != target && k < 100) begin applyStimulus(); k++; end
      checkOutput("waitScan", 32'(curScan()), 32'(target));
   endtask

   task automatic waitFrame();
      int k = 0;
      do begin applyStimulus(); k++; end while (!mFd && k < 100);
      checkOutput("waitFrame", 32'(mFd), 32'd1);
   endtask

   task automatic waitPhase(input int phase);
      int k = 0;
      while ((eCycles % (4 * D)) != phase && k < 100) begin applyStimulus(); k++; end
      checkOutput("waitPhase", 32'(eCycles % (4 * D)), 32'(phase));
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; wr = 1'b0; hexsIn = 0; pointsIn = 0; lesIn = 0;
      applyStimulus();
      applyStimulus();
      checkOutput("rstLEs", 32'(ifA.LEs), 32'hF);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus();
      checkOutput("noCommitLEs", 32'(ifA.LEs), 32'hF);

      // Frame-boundary commit
      waitScan(1);
      writeData(16'h1234, 4'h0, 4'h0);
      checkOutput("pendSet", 32'(ifA.pending), 32'd1);
      checkOutput("holdOld", 32'(ifA.hexs), 32'h0000);
      waitFrame();
      checkOutput("commit1234", 32'(ifA.hexs), 32'h1234);
      checkOutput("pendClr", 32'(ifA.pending), 32'd0);

      // Write colliding with the commit edge
      waitScan(2);
      writeData(16'hAAAA, 4'h0, 4'h0);
      waitPhase(4 * D - 1);
      writeData(16'h5555, 4'h0, 4'h0);
      checkOutput("collOld", 32'(ifA.hexs), 32'hAAAA);
      checkOutput("collPend", 32'(ifA.pending), 32'd1);
      waitFrame();
      checkOutput("collNew", 32'(ifA.hexs), 32'h5555);

      // Leading-zero blanking
      writeData(16'h0070, 4'b0110, 4'h0);
      waitFrame();
      checkOutput("lz0070A", 32'(ifA.LEs), 32'b1100);
      checkOutput("lz0070B", 32'(ifB.LEs), 32'b0000);
      writeData(16'h0000, 4'h0, 4'h0);
      waitFrame();
      checkOutput("lz0000A", 32'(ifA.LEs), 32'b1110);

      // Enable freeze at scan 2, count 1
      waitPhase(2 * D + 1);
      en = 1'b0;
      writeData(16'hBEEF, 4'h0, 4'h0);
      applyStimulus();
      checkOutput("freezeCommit", 32'(ifA.hexs), 32'hBEEF);
      for (int i = 0; i < 8; i++) applyStimulus();
      checkOutput("freezeScan", 32'(ifA.scan), 32'd2);
      en = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("resumeHold", 32'(ifA.scan), 32'd2);
      applyStimulus();
      checkOutput("resumeAdv", 32'(ifA.scan), 32'd3);

      // Reset mid-frame with pending data
      waitPhase(3 * D);
      writeData(16'h4321, 4'h0, 4'h0);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("midRstScan", 32'(ifA.scan), 32'd0);
      checkOutput("midRstPend", 32'(ifA.pending), 32'd0);
      checkOutput("midRstHexs", 32'(ifA.hexs), 32'h0000);
      checkOutput("midRstLEs",  32'(ifA.LEs), 32'hF);
      checkOutput("midRstFd",   32'(ifA.frame_done), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         en       = ($urandom_range(0, 7) != 0);
         wr       = ($urandom_range(0, 4) == 0);
         hexsIn   = 16'($urandom);
         if ($urandom_range(0, 2) == 0) hexsIn = hexsIn & 16'h00FF;
         pointsIn = 4'($urandom);
         lesIn    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
